// File: rtl/mem_loader_pkg.sv
// Shared constants and the loader FSM state type for the calculator preload stage.
package mem_loader_pkg;
  localparam int ADDR_W        = 9;
  localparam int MEM_WORD_SIZE = 64;
  localparam int LOAD_DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
    DONE
  } loader_state_e;
endpackage

// File: rtl/mem_loader_if.sv
// Host-to-loader operand stream: valid/ready handshake carrying one host word per beat.
interface mem_loader_if #(
  parameter int DATA_W = mem_loader_pkg::LOAD_DATA_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/mem_loader.sv
// Packs pairs of host words into 64-bit SRAM words and writes them over an inclusive address window.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W        = mem_loader_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = mem_loader_pkg::MEM_WORD_SIZE,
  parameter int DATA_W        = LOAD_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        load_start_addr,
  input  logic [ADDR_W-1:0]        load_end_addr,
  mem_loader_if.slave              host,
  output logic                     write,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [MEM_WORD_SIZE-1:0] w_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W:0]          words_written
);

  loader_state_e     state, state_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] lo_reg;
  logic              window_bad;

  assign window_bad = (load_end_addr < load_start_addr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    host.in_ready = 1'b0;
    write         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_n = window_bad ? DONE : LO;
      end
      LO: begin
        host.in_ready = 1'b1;
        busy          = 1'b1;
        if (host.in_valid) state_n = HI;
      end
      HI: begin
        host.in_ready = 1'b1;
        busy          = 1'b1;
        if (host.in_valid) state_n = WR;
      end
      WR: begin
        write   = 1'b1;
        busy    = 1'b1;
        state_n = (cur_addr == end_addr) ? DONE : LO;
      end
      DONE: begin
        done = 1'b1;
        if (start_i) state_n = window_bad ? DONE : LO;
      end
      default: state_n = IDLE;
    endcase
  end

  // w_addr/w_data are captured on the second accepted word so they stay stable
  // through WR and hold afterwards while cur_addr advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr      <= '0;
      end_addr      <= '0;
      lo_reg        <= '0;
      w_addr        <= '0;
      w_data        <= '0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            cur_addr      <= load_start_addr;
            end_addr      <= load_end_addr;
            words_written <= '0;
            err           <= window_bad;
          end
        end
        LO: begin
          if (host.in_valid) lo_reg <= host.in_data;
        end
        HI: begin
          if (host.in_valid) begin
            w_data <= {host.in_data, lo_reg};
            w_addr <= cur_addr;
          end
        end
        WR: begin
          words_written <= words_written + (ADDR_W + 1)'(1);
          if (cur_addr != end_addr) cur_addr <= cur_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus queues expected writes, a monitor checks each write pulse.
module tb_mem_loader;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] sa = '0;
  logic [AW-1:0] ea = '0;
  logic          write;
  logic [AW-1:0] w_addr;
  logic [MW-1:0] w_data;
  logic          busy, done, err;
  logic [AW:0]   words_written;

  mem_loader_if #(.DATA_W(DW)) hif ();

  mem_loader #(.ADDR_W(AW), .MEM_WORD_SIZE(MW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .load_start_addr(sa), .load_end_addr(ea),
    .host(hif),
    .write(write), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_writes = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && write) begin
      wr_t e;
      n_writes++;
      chk("in_ready_low_in_wr", {63'd0, hif.in_ready}, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", w_addr, w_data);
      end else begin
        e = sb.pop_front();
        chk("w_addr", {55'd0, w_addr}, {55'd0, e.addr});
        chk("w_data", w_data, e.data);
      end
    end
  end

  task automatic expect_wr(input int addr, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    wr_t e;
    e.addr = AW'(addr);
    e.data = {hi, lo};
    sb.push_back(e);
  endtask

  task automatic do_start(input int s, input int e);
    start = 1'b1;
    sa    = AW'(s);
    ea    = AW'(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the word is accepted.
  task automatic send_word(input logic [DW-1:0] w, input bit gap);
    int n = 0;
    if (gap) begin
      hif.in_valid = 1'b0;
      @(negedge clk);
    end
    hif.in_valid = 1'b1;
    hif.in_data  = w;
    while (!hif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    hif.in_valid = 1'b0;
  endtask

  task automatic chk_done(input string name, input int ww, input bit e);
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_err"}, {63'd0, err}, {63'd0, e});
    chk({name, "_words"}, {54'd0, words_written}, 64'(ww));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_write", {63'd0, write}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ready", {63'd0, hif.in_ready}, 64'd0);
    chk("rst_data", w_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Window 0..3, words 1..8, no stalls.
    expect_wr(0, 32'd2, 32'd1);
    expect_wr(1, 32'd4, 32'd3);
    expect_wr(2, 32'd6, 32'd5);
    expect_wr(3, 32'd8, 32'd7);
    do_start(0, 3);
    for (int i = 1; i <= 8; i++) send_word(DW'(i), 1'b0);
    @(negedge clk);
    chk_done("w0_3", 4, 1'b0);

    // Single-word window with in_valid toggling.
    expect_wr(10, 32'hBBBB1111, 32'hAAAA0000);
    do_start(10, 10);
    send_word(32'hAAAA0000, 1'b1);
    send_word(32'hBBBB1111, 1'b1);
    @(negedge clk);
    chk_done("w10", 1, 1'b0);

    // Inverted window: immediate error, no writes.
    do_start(20, 5);
    chk_done("bad_win", 0, 1'b1);
    chk("bad_win_ready", {63'd0, hif.in_ready}, 64'd0);
    hif.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    hif.in_valid = 1'b0;
    chk("bad_win_writes", 64'(n_writes), 64'd5);

    // Full window 0..511.
    for (int i = 0; i < 512; i++) expect_wr(i, DW'(2 * i + 1), DW'(2 * i));
    do_start(0, 511);
    for (int i = 0; i < 1024; i++) send_word(DW'(i), 1'b0);
    @(negedge clk);
    chk_done("full", 512, 1'b0);
    chk("full_last_addr", {55'd0, w_addr}, 64'd511);

    // Start pulse in HI is ignored.
    expect_wr(30, 32'hC2, 32'hC1);
    expect_wr(31, 32'hC4, 32'hC3);
    do_start(30, 31);
    send_word(32'hC1, 1'b0);
    chk("ign_in_hi", {63'd0, busy}, 64'd1);
    do_start(100, 100);
    send_word(32'hC2, 1'b0);
    send_word(32'hC3, 1'b0);
    send_word(32'hC4, 1'b0);
    @(negedge clk);
    chk_done("ign", 2, 1'b0);

    // Asynchronous reset after 1.5 words.
    do_start(0, 7);
    send_word(32'h11, 1'b0);
    hif.in_valid = 1'b1;
    hif.in_data  = 32'h22;
    #2 rst = 1'b1;
    #1;
    chk("arst_write", {63'd0, write}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_ready", {63'd0, hif.in_ready}, 64'd0);
    chk("arst_addr", {55'd0, w_addr}, 64'd0);
    chk("arst_data", w_data, 64'd0);
    chk("arst_words", {54'd0, words_written}, 64'd0);
    hif.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_wr(0, 32'h44, 32'h33);
    do_start(0, 0);
    send_word(32'h33, 1'b0);
    send_word(32'h44, 1'b0);
    @(negedge clk);
    chk_done("after_rst", 1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("total_writes", 64'(n_writes), 64'd520);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
